// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Purpose: bundles every handshake and bus signal around the fetch stage so
// the fetch unit and its environment connect through a single port.
//
// Signal groups:
//   PC side      : pc, pc_valid (to fetch), pc_ready (from fetch), flush
//   Memory side  : imem_req, imem_addr (from fetch),
//                  imem_gnt, imem_rvalid, imem_rdata (to fetch)
//   Decode side  : instr_valid, instr, instr_pc, instr_misaligned (from
//                  fetch), instr_ready (to fetch)
//
// Modports:
//   slave  : the fetch unit's view
//   master : the surrounding pipeline / memory / testbench view
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_misaligned;
    logic        instr_ready;

    modport slave (
        input  pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output pc_ready, imem_req, imem_addr,
               instr_valid, instr, instr_pc, instr_misaligned
    );

    modport master (
        output pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  pc_ready, imem_req, imem_addr,
               instr_valid, instr, instr_pc, instr_misaligned
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: fetch stage downstream of the program counter. Accepts a fetch
// address over a valid/ready handshake, issues one word read at a time to
// instruction memory (req/gnt/rvalid), and queues returned instructions
// tagged with their PC in a small FIFO for decode. Misaligned addresses are
// not sent to memory; a NOP tagged as misaligned is queued instead. A flush
// empties the queue and discards any read still in flight.
//
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high
//   bus   : instr_fetch_unit_if.slave carrying the PC, memory and decode
//           handshakes
//
// Parameters:
//   FIFO_DEPTH : instruction queue entries (power of two, >= 2)
//   NOP_INSTR  : word substituted for misaligned fetches
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_unit_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        DISCARD
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pending_pc_q, pending_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        fifo_instr_q [FIFO_DEPTH];
    logic [31:0]        fifo_instr_d [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]        fifo_pc_d    [FIFO_DEPTH];
    logic               fifo_mis_q   [FIFO_DEPTH];
    logic               fifo_mis_d   [FIFO_DEPTH];

    logic        credit;
    logic        pc_aligned;
    logic        can_accept;
    logic        mem_req;
    logic        issue;
    logic        nop_push;
    logic        rsp_push;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic [31:0] push_instr;
    logic [31:0] push_pc;
    logic        push_mis;

    // Handshake decode. Credit counts the in-flight read as an occupied slot
    // so a response can always be queued, and it uses the registered count,
    // so a pop only frees space for a new fetch from the following cycle.
    always_comb begin
        credit     = (count_q + CNT_W'(state_q == WAIT_DATA)) < CNT_W'(FIFO_DEPTH);
        pc_aligned = (bus.pc[1:0] == 2'b00);
        can_accept = (state_q == IDLE) && bus.pc_valid && credit && !bus.flush && !reset;
        mem_req    = can_accept && pc_aligned;
        issue      = mem_req && bus.imem_gnt;
        nop_push   = can_accept && !pc_aligned;
        rsp_push   = (state_q == WAIT_DATA) && bus.imem_rvalid && !bus.flush;
        push       = nop_push || rsp_push;
        head_valid = (count_q != '0);
        pop        = head_valid && bus.instr_ready && !bus.flush;
        push_instr = rsp_push ? bus.imem_rdata : NOP_INSTR;
        push_pc    = rsp_push ? pending_pc_q   : bus.pc;
        push_mis   = !rsp_push;
    end

    // Next-state logic. A response arriving in the same cycle as a flush is
    // simply dropped; without a response the FSM parks in DISCARD until the
    // orphaned read returns, keeping the one-outstanding rule intact.
    always_comb begin
        state_d      = state_q;
        pending_pc_d = pending_pc_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d      = WAIT_DATA;
                    pending_pc_d = bus.pc;
                end
            end
            WAIT_DATA: begin
                if (bus.imem_rvalid) begin
                    state_d = IDLE;
                end else if (bus.flush) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction queue update; flush wins over any push or pop.
    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_mis_d   = fifo_mis_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = push_instr;
                fifo_pc_d[wr_ptr_q]    = push_pc;
                fifo_mis_d[wr_ptr_q]   = push_mis;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_pc_q <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_mis_q[i]   <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            pending_pc_q <= pending_pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_mis_q   <= fifo_mis_d;
        end
    end

    // Outputs are forced quiet while reset is held, even before the first
    // reset edge has cleared the registers.
    assign bus.imem_req         = mem_req;
    assign bus.imem_addr        = {bus.pc[31:2], 2'b00};
    assign bus.pc_ready         = issue || nop_push;
    assign bus.instr_valid      = head_valid && !reset;
    assign bus.instr            = reset ? 32'h0 : fifo_instr_q[rd_ptr_q];
    assign bus.instr_pc         = reset ? 32'h0 : fifo_pc_q[rd_ptr_q];
    assign bus.instr_misaligned = reset ? 1'b0  : fifo_mis_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives directed fetch scenarios into instr_fetch_unit. Every instruction
// expected at the decode side is pushed into a scoreboard queue when its
// fetch is issued; an independent monitor pops and compares whenever decode
// consumes the FIFO head. Handshake outputs are also checked directly.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } exp_entry_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    exp_entry_t sb[$];
    exp_entry_t monExp;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .FIFO_DEPTH (2),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check steps the two counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus: inputs change just after the rising edge
    // and the task returns at the falling edge, where outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic [31:0] pcVal,
                                 input logic pcValid, input logic gnt,
                                 input logic rvalid, input logic [31:0] rdata,
                                 input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.pc          = pcVal;
        bus.pc_valid    = pcValid;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rvalid;
        bus.imem_rdata  = rdata;
        bus.flush       = fl;
        bus.instr_ready = rdy;
        @(negedge clk);
    endtask

    // Monitor: whenever decode takes the head, it must match the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_instr actual pc=%h instr=%h required=no_entry",
                         bus.instr_pc, bus.instr);
            end else begin
                monExp = sb.pop_front();
                checkOutput("instr", bus.instr, monExp.instr);
                checkOutput("instr_pc", bus.instr_pc, monExp.pc);
                checkOutput("instr_misaligned", 32'(bus.instr_misaligned), 32'(monExp.mis));
            end
        end
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        bus.pc          = 32'h0;
        bus.pc_valid    = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;

        // Reset: outputs quiet even with a valid pc offered.
        applyStimulus(1, 32'h0, 1, 1, 0, 32'h0, 0, 1);
        applyStimulus(1, 32'h0, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_instr", bus.instr, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_instr_mis", 32'(bus.instr_misaligned), 32'd0);

        // Basic fetch, zero-wait memory.
        applyStimulus(0, 32'h00, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t1_imem_req", 32'(bus.imem_req), 32'd1);
        checkOutput("t1_pc_ready", 32'(bus.pc_ready), 32'd1);
        checkOutput("t1_imem_addr", bus.imem_addr, 32'h00);
        sb.push_back({32'h0050_0093, 32'h00, 1'b0});
        applyStimulus(0, 32'h04, 0, 0, 1, 32'h0050_0093, 0, 1);
        checkOutput("t1_no_bypass", 32'(bus.instr_valid), 32'd0);
        applyStimulus(0, 32'h04, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("t1_latency_valid", 32'(bus.instr_valid), 32'd1);
        applyStimulus(0, 32'h04, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("t1_drained", 32'(bus.instr_valid), 32'd0);

        // FIFO full back-pressure with decode stalled.
        applyStimulus(0, 32'h00, 1, 1, 0, 32'h0, 0, 0);
        sb.push_back({32'h0010_0113, 32'h00, 1'b0});
        applyStimulus(0, 32'h04, 0, 0, 1, 32'h0010_0113, 0, 0);
        applyStimulus(0, 32'h04, 1, 1, 0, 32'h0, 0, 0);
        checkOutput("t2_second_accept", 32'(bus.pc_ready), 32'd1);
        sb.push_back({32'h0020_0193, 32'h04, 1'b0});
        applyStimulus(0, 32'h08, 0, 0, 1, 32'h0020_0193, 0, 0);
        applyStimulus(0, 32'h08, 1, 1, 0, 32'h0, 0, 0);
        checkOutput("t2_full_req", 32'(bus.imem_req), 32'd0);
        checkOutput("t2_full_ready", 32'(bus.pc_ready), 32'd0);
        checkOutput("t2_head_pc_held", bus.instr_pc, 32'h00);
        applyStimulus(0, 32'h08, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t2_pop_cycle_req", 32'(bus.imem_req), 32'd0);
        applyStimulus(0, 32'h08, 1, 1, 0, 32'h0, 0, 0);
        checkOutput("t2_after_pop_req", 32'(bus.imem_req), 32'd1);
        checkOutput("t2_after_pop_ready", 32'(bus.pc_ready), 32'd1);
        sb.push_back({32'h0030_0213, 32'h08, 1'b0});
        applyStimulus(0, 32'h0C, 0, 0, 1, 32'h0030_0213, 0, 0);
        applyStimulus(0, 32'h0C, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 32'h0C, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 32'h0C, 0, 0, 0, 32'h0, 0, 1);

        // Flush with a read in flight; late data must be dropped.
        applyStimulus(0, 32'h10, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t3_accept", 32'(bus.pc_ready), 32'd1);
        applyStimulus(0, 32'h14, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("t3_flush_req", 32'(bus.imem_req), 32'd0);
        applyStimulus(0, 32'h40, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t3_discard_req", 32'(bus.imem_req), 32'd0);
        checkOutput("t3_discard_ready", 32'(bus.pc_ready), 32'd0);
        applyStimulus(0, 32'h40, 1, 1, 1, 32'hDEAD_BEEF, 0, 1);
        checkOutput("t3_drop_cycle_req", 32'(bus.imem_req), 32'd0);
        applyStimulus(0, 32'h40, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t3_reissue_req", 32'(bus.imem_req), 32'd1);
        checkOutput("t3_reissue_addr", bus.imem_addr, 32'h40);
        sb.push_back({32'h0000_0517, 32'h40, 1'b0});
        applyStimulus(0, 32'h44, 0, 0, 1, 32'h0000_0517, 0, 1);
        applyStimulus(0, 32'h44, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 32'h44, 0, 0, 0, 32'h0, 0, 1);

        // Misaligned pc becomes a NOP without touching memory.
        applyStimulus(0, 32'h06, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t4_no_req", 32'(bus.imem_req), 32'd0);
        checkOutput("t4_ready", 32'(bus.pc_ready), 32'd1);
        sb.push_back({32'h0000_0013, 32'h06, 1'b1});
        applyStimulus(0, 32'h08, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("t4_valid_next", 32'(bus.instr_valid), 32'd1);
        applyStimulus(0, 32'h08, 0, 0, 0, 32'h0, 0, 1);

        // Grant withheld for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h20, 1, 0, 0, 32'h0, 0, 1);
            checkOutput("t5_stall_req", 32'(bus.imem_req), 32'd1);
            checkOutput("t5_stall_addr", bus.imem_addr, 32'h20);
            checkOutput("t5_stall_ready", 32'(bus.pc_ready), 32'd0);
        end
        applyStimulus(0, 32'h20, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t5_grant_ready", 32'(bus.pc_ready), 32'd1);
        sb.push_back({32'h00A0_0293, 32'h20, 1'b0});
        applyStimulus(0, 32'h24, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 32'h24, 0, 0, 1, 32'h00A0_0293, 0, 1);
        applyStimulus(0, 32'h24, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 32'h24, 0, 0, 0, 32'h0, 0, 1);

        // Reset while waiting for data; the late response is ignored.
        applyStimulus(0, 32'h30, 1, 1, 0, 32'h0, 0, 1);
        applyStimulus(1, 32'h34, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("t6_rst_req", 32'(bus.imem_req), 32'd0);
        applyStimulus(0, 32'h34, 0, 0, 1, 32'hBAD0_BAD0, 0, 1);
        applyStimulus(0, 32'h34, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("t6_ignored_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("t6_idle_req", 32'(bus.imem_req), 32'd1);
        sb.push_back({32'h00B0_0313, 32'h34, 1'b0});
        applyStimulus(0, 32'h38, 0, 0, 1, 32'h00B0_0313, 0, 1);
        applyStimulus(0, 32'h38, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(0, 32'h38, 0, 0, 0, 32'h0, 0, 1);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly downstream of the program counter. Accepts the current fetch address over a valid/ready handshake and issues word reads to instruction memory through a request/grant/response port. Buffers returned instructions, each tagged with its PC, in a small FIFO for the decode stage. On a control-flow redirect it flushes queued and in-flight fetches.

## Interface
- FIFO_DEPTH, 2: instruction queue entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013: instruction word substituted for misaligned fetches (addi x0,x0,0).

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- pc  in  32  fetch address from the program counter.
- pc_valid  in  1  pc is a valid fetch request.
- pc_ready  out  1  fetch address accepted this cycle; the PC advances only when pc_valid && pc_ready.
- flush  in  1  redirect (taken branch, jal, jalr); discards all queued and in-flight fetches.
- imem_req  out  1  memory read request.
- imem_addr  out  32  word-aligned read address; equals pc while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  FIFO head instruction.
- instr_pc  out  32  PC of the FIFO head.
- instr_misaligned  out  1  FIFO head came from a pc with pc[1:0]!=0.
- instr_ready  in  1  decode pops the head when instr_valid && instr_ready.

## Operation
- FSM states: IDLE, WAIT_DATA, DISCARD.
- At most one memory request outstanding. credit = (count + outstanding) < FIFO_DEPTH; outstanding = (state==WAIT_DATA).
- IDLE, aligned pc: imem_req = pc_valid && credit && !flush && !reset (combinational). pc_ready = imem_req && imem_gnt. On acceptance, latch pc as pending_pc and go to WAIT_DATA. If gnt=0, hold request; pc must remain stable until accepted.
- IDLE, misaligned pc (pc[1:0]!=0): no memory request. If pc_valid && credit && !flush, pc_ready=1 and push {NOP_INSTR, pc, misaligned=1} directly; remain in IDLE.
- WAIT_DATA: imem_req=0, pc_ready=0. On imem_rvalid, push {imem_rdata, pending_pc, 0} and go to IDLE. Response is guaranteed no earlier than the cycle after grant.
- flush: clears the FIFO (count=0) at the next edge; pc_ready=0 and imem_req=0 that cycle. If in WAIT_DATA without rvalid, go to DISCARD; with rvalid in the same cycle, drop the data and go to IDLE. Flush in DISCARD stays in DISCARD.
- DISCARD: imem_req=0, pc_ready=0; on imem_rvalid drop the data and go to IDLE.
- FIFO: simultaneous push and pop are allowed at any count, including full (a pop frees the slot in the same cycle for credit purposes only at the next edge; credit uses registered count). A pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- Flush takes priority over push and pop in the same cycle.

## Timing
- Reset (sync): state=IDLE, count=0, read/write pointers=0, pending_pc=0. While reset=1: imem_req=0, pc_ready=0, instr_valid=0, instr=0, instr_pc=0, instr_misaligned=0.
- Reset asserted mid-fetch: the outstanding response arriving after reset deasserts is ignored (state is IDLE and rvalid in IDLE is discarded).
- Latency: grant in cycle N, rvalid in cycle N+k (k≥1), instr_valid=1 in N+k+1. No bypass.
- Misaligned: pc accepted in N -> instr_valid in N+1.
- Peak throughput: one instruction per 2 cycles with a zero-wait memory (k=1).
- instr, instr_pc, instr_misaligned are registered FIFO outputs, stable while instr_valid && !instr_ready.

## Test plan
- Reset then pc=0x00, gnt=1, rvalid next cycle with rdata=0x00500093 -> instr_valid one cycle later, instr=0x00500093, instr_pc=0x00.
- instr_ready=0, fetch 0x00 and 0x04 -> FIFO full (DEPTH=2); third pc 0x08 gets pc_ready=0 and imem_req=0 until one pop, then it is accepted.
- Grant at 0x10, flush asserted the next cycle, rvalid two cycles later with 0xDEADBEEF -> nothing enqueued; the next pc 0x40 is issued only after the drop, and its data appears with instr_pc=0x40.
- pc=0x06 -> no imem_req; instr=0x00000013, instr_pc=0x06, instr_misaligned=1 one cycle later.
- imem_gnt held 0 for 3 cycles -> imem_req and imem_addr stay stable, pc_ready=0; on the grant cycle pc_ready=1.
- Reset asserted while in WAIT_DATA; rvalid arrives after release -> instr_valid stays 0, FSM is in IDLE, and the next fetch proceeds normally.
